// File: rtl/rbm_argmax_classifier.sv
// rtl/rbm_argmax_classifier.sv - serial argmax over the RBM core's packed class scores
//
// Purpose: on the rising edge of score_valid, capture all output_dim signed scores,
// scan them one per cycle for the maximum and runner-up, then offer the winning
// index, its score and the margin on a valid/ready handshake.
//
// Ports:
//   clock, reset    rising-edge clock, asynchronous active-high reset
//   score_valid     core finish flag (level); its rising edge starts a capture
//   ScorePort       packed scores, score i at [i*w_bitlength +: w_bitlength]
//   result_ready    consumer accepts the result (only looked at in HOLD)
//   result_valid    result fields valid (HOLD)
//   class_idx       index of the maximum score (lowest index on ties)
//   class_score     maximum score, signed
//   margin          best minus runner-up, w_bitlength+1 bits, never negative
//   busy            high in SCAN or HOLD
//   overrun         sticky: a start edge arrived while busy
//   class_count     completed handshakes, wraps
module rbm_argmax_classifier #(
  parameter int output_dim    = 10,
  parameter int w_bitlength   = 12,
  parameter int idx_bitlength = 4,
  parameter int cnt_bitlength = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              score_valid,
  input  logic [output_dim*w_bitlength-1:0] ScorePort,
  input  logic                              result_ready,
  output logic                              result_valid,
  output logic [idx_bitlength-1:0]          class_idx,
  output logic [w_bitlength-1:0]            class_score,
  output logic [w_bitlength:0]              margin,
  output logic                              busy,
  output logic                              overrun,
  output logic [cnt_bitlength-1:0]          class_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [idx_bitlength-1:0] LAST_K = idx_bitlength'(output_dim - 1);
  localparam logic signed [w_bitlength-1:0] MOST_NEG = {1'b1, {(w_bitlength-1){1'b0}}};

  state_t r_state;
  state_t w_next;

  logic                            r_sv_d;
  logic signed [w_bitlength-1:0]   r_scores [output_dim];
  logic signed [w_bitlength-1:0]   r_best;
  logic signed [w_bitlength-1:0]   r_second;
  logic [idx_bitlength-1:0]        r_idx;
  logic [idx_bitlength-1:0]        r_k;

  logic                            w_start;
  logic signed [w_bitlength-1:0]   w_sk;
  logic signed [w_bitlength-1:0]   w_nbest;
  logic signed [w_bitlength-1:0]   w_nsecond;
  logic [idx_bitlength-1:0]        w_nidx;

  assign w_start      = score_valid & ~r_sv_d;
  assign result_valid = (r_state == HOLD);
  assign busy         = (r_state != IDLE);

  // One compare step; strict greater-than keeps the lower index on ties, and a tie
  // with best falls through to the second branch, making second equal to best.
  always_comb begin
    w_sk      = r_scores[r_k];
    w_nbest   = r_best;
    w_nsecond = r_second;
    w_nidx    = r_idx;
    if (w_sk > r_best) begin
      w_nsecond = r_best;
      w_nbest   = w_sk;
      w_nidx    = r_k;
    end else if (w_sk > r_second) begin
      w_nsecond = w_sk;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = SCAN;
      SCAN:    if (r_k == LAST_K) w_next = HOLD;
      HOLD:    if (result_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sv_d      <= 1'b0;
      r_best      <= '0;
      r_second    <= '0;
      r_idx       <= '0;
      r_k         <= '0;
      class_idx   <= '0;
      class_score <= '0;
      margin      <= '0;
      overrun     <= 1'b0;
      class_count <= '0;
      for (int i = 0; i < output_dim; i++) r_scores[i] <= '0;
    end else begin
      r_sv_d <= score_valid;
      // Start edges while busy (including the HOLD handshake edge) are dropped.
      if (w_start && r_state != IDLE) overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            for (int i = 0; i < output_dim; i++)
              r_scores[i] <= ScorePort[i*w_bitlength +: w_bitlength];
            r_best   <= ScorePort[w_bitlength-1:0];
            r_second <= MOST_NEG;
            r_idx    <= '0;
            r_k      <= idx_bitlength'(1);
          end
        end
        SCAN: begin
          r_best   <= w_nbest;
          r_second <= w_nsecond;
          r_idx    <= w_nidx;
          r_k      <= r_k + 1'b1;
          // Results are registered from the final compare so they appear with result_valid.
          if (r_k == LAST_K) begin
            class_idx   <= w_nidx;
            class_score <= w_nbest;
            margin      <= {w_nbest[w_bitlength-1], w_nbest} - {w_nsecond[w_bitlength-1], w_nsecond};
          end
        end
        HOLD: begin
          if (result_ready) class_count <= class_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rbm_argmax_classifier.sv
// tb/tb_rbm_argmax_classifier.sv - self-checking bench for rbm_argmax_classifier
module tb_rbm_argmax_classifier;

  localparam int ND = 10;
  localparam int W  = 12;
  localparam int IW = 4;
  localparam int CW = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            score_valid = 1'b0;
  logic [ND*W-1:0] ScorePort = '0;
  logic            result_ready = 1'b0;
  logic            result_valid;
  logic [IW-1:0]   class_idx;
  logic [W-1:0]    class_score;
  logic [W:0]      margin;
  logic            busy;
  logic            overrun;
  logic [CW-1:0]   class_count;

  rbm_argmax_classifier #(
    .output_dim(ND), .w_bitlength(W), .idx_bitlength(IW), .cnt_bitlength(CW)
  ) dut (
    .clock(clock), .reset(reset), .score_valid(score_valid), .ScorePort(ScorePort),
    .result_ready(result_ready), .result_valid(result_valid), .class_idx(class_idx),
    .class_score(class_score), .margin(margin), .busy(busy), .overrun(overrun),
    .class_count(class_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;
  int exp_idx, exp_best, exp_margin;
  logic signed [W-1:0] sc [ND];

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: first index holding the maximum; runner-up is the largest of the rest.
  task automatic model();
    int sec;
    exp_idx = 0;
    for (int i = 1; i < ND; i++) if (int'(sc[i]) > int'(sc[exp_idx])) exp_idx = i;
    exp_best = int'(sc[exp_idx]);
    sec = -1000000;
    for (int j = 0; j < ND; j++) if (j != exp_idx && int'(sc[j]) > sec) sec = int'(sc[j]);
    exp_margin = exp_best - sec;
  endtask

  task automatic pack();
    for (int i = 0; i < ND; i++) ScorePort[i*W +: W] = sc[i];
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid"}, int'(result_valid), 1);
    check({tag, "_idx"},   int'(class_idx), exp_idx);
    check({tag, "_score"}, int'($signed(class_score)), exp_best);
    check({tag, "_margin"}, int'(margin), exp_margin);
  endtask

  // Raise the finish flag, capture, then wait for result_valid and check latency.
  task automatic start_and_wait(input string tag);
    int lat;
    model();
    @(negedge clock);
    pack();
    score_valid = 1'b1;
    @(posedge clock);
    #1 score_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clock);
      #1 lat++;
    end while (!result_valid && lat < 40);
    check({tag, "_latency"}, lat, ND - 1);
    check_result(tag);
  endtask

  task automatic handshake(input string tag);
    @(negedge clock);
    result_ready = 1'b1;
    @(posedge clock);
    #1 result_ready = 1'b0;
    exp_count++;
    check({tag, "_hs_valid"}, int'(result_valid), 0);
    check({tag, "_hs_count"}, int'(class_count), exp_count);
    check({tag, "_hs_busy"},  int'(busy), 0);
    check({tag, "_hs_idx_kept"}, int'(class_idx), exp_idx);
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_valid", int'(result_valid), 0);
    check("rst_idx", int'(class_idx), 0);
    check("rst_score", int'(class_score), 0);
    check("rst_margin", int'(margin), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_count", int'(class_count), 0);
    @(negedge clock);
    reset = 1'b0;

    // 1: clear winner at index 2
    for (int i = 0; i < ND; i++) sc[i] = '0;
    sc[0] = 12'sd5; sc[1] = -12'sd3; sc[2] = 12'sd100;
    start_and_wait("t1");
    check("t1_const_idx", int'(class_idx), 2);
    check("t1_const_margin", int'(margin), 95);
    handshake("t1");

    // 2: extremes
    for (int i = 0; i < ND; i++) sc[i] = 12'h800;
    sc[7] = 12'h7FF;
    start_and_wait("t2");
    check("t2_const_margin", int'(margin), 4095);
    handshake("t2");

    // 3: tie between 3 and 8
    for (int i = 0; i < ND; i++) sc[i] = -12'sd10;
    sc[3] = 12'sd40; sc[8] = 12'sd40;
    start_and_wait("t3");
    check("t3_const_idx", int'(class_idx), 3);
    handshake("t3");

    // 4: back-pressure holds outputs stable
    for (int i = 0; i < ND; i++) sc[i] = W'($urandom_range(0, 4095));
    start_and_wait("t4");
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1 check_result("t4_hold");
    end
    handshake("t4");

    // Random scores; even iterations use a narrow range to force ties.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < ND; i++)
        sc[i] = (it % 2 == 0) ? W'(int'($urandom_range(0, 6)) - 3) : W'($urandom_range(0, 4095));
      start_and_wait("rnd");
      handshake("rnd");
    end

    // 5: second start edge three cycles into SCAN is ignored
    begin
      int lat;
      for (int i = 0; i < ND; i++) sc[i] = W'($urandom_range(0, 4095));
      model();
      @(negedge clock);
      pack();
      score_valid = 1'b1;
      @(posedge clock);
      #1 score_valid = 1'b0;
      lat = 0;
      repeat (2) begin @(posedge clock); #1 lat++; end
      for (int i = 0; i < ND; i++) ScorePort[i*W +: W] = W'($urandom_range(0, 4095));
      score_valid = 1'b1;
      @(posedge clock);
      #1 lat++;
      score_valid = 1'b0;
      check("t5_overrun", int'(overrun), 1);
      check("t5_busy", int'(busy), 1);
      do begin
        @(posedge clock);
        #1 lat++;
      end while (!result_valid && lat < 40);
      check("t5_latency", lat, ND - 1);
      check_result("t5");
      handshake("t5");
      check("t5_overrun_sticky", int'(overrun), 1);
    end

    // 6: reset at k=5 aborts, next run is clean
    for (int i = 0; i < ND; i++) sc[i] = W'($urandom_range(0, 4095));
    @(negedge clock);
    pack();
    score_valid = 1'b1;
    @(posedge clock);
    #1 score_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_valid", int'(result_valid), 0);
    check("t6_rst_idx", int'(class_idx), 0);
    check("t6_rst_score", int'(class_score), 0);
    check("t6_rst_margin", int'(margin), 0);
    check("t6_rst_overrun", int'(overrun), 0);
    check("t6_rst_count", int'(class_count), 0);
    exp_count = 0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < ND; i++) sc[i] = W'($urandom_range(0, 4095));
    start_and_wait("t6");
    handshake("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
